// File: rtl/lilme_req_arbiter.sv
// Round-robin front end that shares one LilME matrix engine between NREQ clients.
// Issues one command at a time, tracks the engine Busy handshake and routes the result back.
module lilme_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int dw      = 31,
    parameter int ACK_TMO = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [3*NREQ-1:0]         req_opcode,
    input  logic [NREQ-1:0]           req_a,
    input  logic [NREQ-1:0]           req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           rsp_valid,
    output logic                      rsp_err,
    output logic [dw:0]               rsp_result,
    output logic [2:0]                me_opcode,
    output logic                      me_a,
    output logic                      me_b,
    input  logic                      me_busy,
    input  logic [dw:0]               me_result,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        RUN,
        RESP
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [IW-1:0]   rr;
    logic [IW-1:0]   gid_q;
    logic [2:0]      opc_q;
    logic            a_q;
    logic            b_q;
    logic [3:0]      cnt;
    logic            err_q;
    logic [dw:0]     result_q;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     cand;
    logic [2:0]      sel_op;
    logic            sel_a;
    logic            sel_b;
    logic            accept;
    logic            capture;
    logic            tmo;

    // Round-robin search starting at rr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!found && req_valid[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = 1'b0;
        sel_b  = 1'b0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (pick == IW'(j)) begin
                sel_op = req_opcode[3*j +: 3];
                sel_a  = req_a[j];
                sel_b  = req_b[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = '0;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        me_opcode = '0;
        me_a      = 1'b0;
        me_b      = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!me_busy && found) begin
                    accept          = 1'b1;
                    req_ready[pick] = 1'b1;
                    state_n         = (sel_op == 3'b000) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                me_opcode = opc_q;
                me_a      = a_q;
                me_b      = b_q;
                state_n   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (me_busy) begin
                    state_n = RUN;
                end else if (cnt == 4'(ACK_TMO - 1)) begin
                    tmo     = 1'b1;
                    state_n = RESP;
                end
            end
            RUN: begin
                if (!me_busy) begin
                    capture = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                rsp_valid[gid_q] = 1'b1;
                rsp_err          = err_q;
                state_n          = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Reset is synchronous, but the Mealy outputs must stay quiet while it is held.
        if (reset) begin
            req_ready = '0;
            rsp_valid = '0;
            rsp_err   = 1'b0;
            me_opcode = '0;
            me_a      = 1'b0;
            me_b      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr       <= '0;
            gid_q    <= '0;
            opc_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            cnt      <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            if (accept) begin
                opc_q <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                gid_q <= pick;
                rr    <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                err_q <= (sel_op == 3'b000);
                if (sel_op == 3'b000) begin
                    result_q <= '0;
                end
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT_ACK && !me_busy) begin
                cnt <= cnt + 1'b1;
            end
            if (tmo) begin
                err_q    <= 1'b1;
                result_q <= '0;
            end
            if (capture) begin
                err_q    <= 1'b0;
                result_q <= me_result;
            end
        end
    end

    assign rsp_result = result_q;
    assign grant_id   = gid_q;

endmodule
